vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_timing_gen.sv | 84 ++++++++
 tb/tb_vga_timing_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz) used by the timing generator
// and by the downstream pixel stage, plus a small decode helper.
package vga_pkg;

  localparam int H_PIXELS_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int H_TOTAL_DEF  = H_PIXELS_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_PIXELS_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;
  localparam int V_TOTAL_DEF  = V_PIXELS_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Counters are 10 bits; window bounds are one bit wider so an upper bound of
  // exactly 1024 is representable.
  localparam int POS_W = 10;

  // True when lo <= pos < hi.
  function automatic logic in_window(input logic [POS_W:0] pos,
                                     input logic [POS_W:0] lo,
                                     input logic [POS_W:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical position counters with registered
// sync, display-enable, line/frame pulses and a frame counter. Every output is
// decoded from the next position so all ports describe the same (h,v) cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_PIXELS = V_PIXELS_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic       clk_25,
  input  logic       sys_reset,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_disp_en,
  output logic [9:0] vga_pos_hor,
  output logic [9:0] vga_pos_ver,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_PIXELS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_PIXELS + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS   = 11'(H_PIXELS);
  localparam logic [10:0] V_VIS   = 11'(V_PIXELS);
  localparam logic [10:0] HS_LO   = 11'(H_PIXELS + H_FRONT);
  localparam logic [10:0] HS_HI   = 11'(H_PIXELS + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_LO   = 11'(V_PIXELS + V_FRONT);
  localparam logic [10:0] VS_HI   = 11'(V_PIXELS + V_FRONT + V_SYNC);

  logic       h_wrap;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;

  // Next position: h always advances, v advances only when h wraps.
  always_comb begin
    h_wrap = (vga_pos_hor == H_LAST);
    h_nxt  = h_wrap ? 10'd0 : vga_pos_hor + 10'd1;
    v_nxt  = vga_pos_ver;
    if (h_wrap) begin
      v_nxt = (vga_pos_ver == V_LAST) ? 10'd0 : vga_pos_ver + 10'd1;
    end
    h_ext = {1'b0, h_nxt};
    v_ext = {1'b0, v_nxt};
  end

  // Register position and all decoded outputs together; reset parks the
  // counters on the last position so the first edge lands on (0,0).
  always_ff @(posedge clk_25 or posedge sys_reset) begin
    if (sys_reset) begin
      vga_pos_hor <= H_LAST;
      vga_pos_ver <= V_LAST;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_disp_en <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'hFF;
    end else begin
      vga_pos_hor <= h_nxt;
      vga_pos_ver <= v_nxt;
      vga_hsync   <= ~in_window(h_ext, HS_LO, HS_HI);
      vga_vsync   <= ~in_window(v_ext, VS_LO, VS_HI);
      vga_disp_en <= (h_ext < H_VIS) && (v_ext < V_VIS);
      line_start  <= (h_nxt == 10'd0);
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
      if ((h_nxt == 10'd0) && (v_nxt == 10'd0)) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a reduced raster (15 x 11, 165 clocks/frame)
// so 256 frames fit in a short run. A cycle-index model derives every output
// from the elapsed clock count since reset release.
module tb_vga_timing_gen;

  localparam int HP = 8, HF = 2, HS = 3, HB = 2;
  localparam int VP = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HP + HF + HS + HB;   // 15
  localparam int VT = VP + VF + VS + VB;   // 11

  logic       clk_25;
  logic       sys_reset;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_disp_en;
  logic [9:0] vga_pos_hor;
  logic [9:0] vga_pos_ver;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  int  vectors = 0;
  int  miscompares = 0;
  int  t = 0;
  bit  run = 0;

  vga_timing_gen #(
    .H_PIXELS(HP), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_PIXELS(VP), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk_25      (clk_25),
    .sys_reset   (sys_reset),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_disp_en (vga_disp_en),
    .vga_pos_hor (vga_pos_hor),
    .vga_pos_ver (vga_pos_ver),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // Elapsed-clock tracker: t is the number of edges since reset release, 0 at (0,0).
  always @(posedge clk_25) begin
    if (!sys_reset) begin
      if (!run) begin
        run = 1'b1;
        t = 0;
      end else begin
        t = t + 1;
      end
    end
  end

  // Per-cycle compare against the model, plus width/period measurements.
  int hs_low = 0, vs_low = 0, since_fs = -1;
  always @(negedge clk_25) begin
    int h, v, fc;
    if (sys_reset) begin
      chk("rst_hor", int'(vga_pos_hor), HT - 1);
      chk("rst_ver", int'(vga_pos_ver), VT - 1);
      chk("rst_hsync", int'(vga_hsync), 1);
      chk("rst_vsync", int'(vga_vsync), 1);
      chk("rst_disp_en", int'(vga_disp_en), 0);
      chk("rst_line_start", int'(line_start), 0);
      chk("rst_frame_start", int'(frame_start), 0);
      chk("rst_frame_count", int'(frame_count), 255);
      since_fs = -1;
    end else if (run) begin
      h  = t % HT;
      v  = (t / HT) % VT;
      fc = (t / (HT * VT)) % 256;
      chk("hor", int'(vga_pos_hor), h);
      chk("ver", int'(vga_pos_ver), v);
      chk("disp_en", int'(vga_disp_en), int'(h < HP && v < VP));
      chk("hsync", int'(vga_hsync), int'(!(h >= HP + HF && h < HP + HF + HS)));
      chk("vsync", int'(vga_vsync), int'(!(v >= VP + VF && v < VP + VF + VS)));
      chk("line_start", int'(line_start), int'(h == 0));
      chk("frame_start", int'(frame_start), int'(h == 0 && v == 0));
      chk("frame_count", int'(frame_count), fc);

      if (h == 0) hs_low = 0;
      if (!vga_hsync) hs_low++;
      if (h == HT - 1) chk("hsync_width", hs_low, 3);

      if (h == 0 && v == 0) vs_low = 0;
      if (!vga_vsync) vs_low++;
      if (h == HT - 1 && v == VT - 1) chk("vsync_width", vs_low, 30);

      if (frame_start) begin
        if (since_fs >= 0) chk("frame_period", since_fs, 165);
        since_fs = 0;
      end
      if (since_fs >= 0) since_fs++;
    end
  end

  task automatic first_edge_checks(input string tag);
    @(posedge clk_25); #1;
    chk({tag, "_hor"}, int'(vga_pos_hor), 0);
    chk({tag, "_ver"}, int'(vga_pos_ver), 0);
    chk({tag, "_disp_en"}, int'(vga_disp_en), 1);
    chk({tag, "_line_start"}, int'(line_start), 1);
    chk({tag, "_frame_start"}, int'(frame_start), 1);
    chk({tag, "_frame_count"}, int'(frame_count), 0);
  endtask

  initial begin
    sys_reset = 1'b1;
    repeat (3) @(negedge clk_25);
    sys_reset = 1'b0;
    first_edge_checks("first");

    // Line 0 boundaries: last visible pixel h=7, first blank h=8, sync h=10..12.
    repeat (7) @(posedge clk_25); #1;
    chk("h7_disp_en", int'(vga_disp_en), 1);
    @(posedge clk_25); #1;
    chk("h8_disp_en", int'(vga_disp_en), 0);
    repeat (2) @(posedge clk_25); #1;
    chk("h10_hsync", int'(vga_hsync), 0);
    repeat (3) @(posedge clk_25); #1;
    chk("h13_hsync", int'(vga_hsync), 1);

    // Next frame start at t=165.
    repeat (165 - 13) @(posedge clk_25); #1;
    chk("f1_frame_start", int'(frame_start), 1);
    chk("f1_frame_count", int'(frame_count), 1);

    // Frame 255, then wrap to 0.
    repeat (254 * 165) @(posedge clk_25); #1;
    chk("f255_frame_start", int'(frame_start), 1);
    chk("f255_frame_count", int'(frame_count), 255);
    repeat (165) @(posedge clk_25); #1;
    chk("f256_frame_start", int'(frame_start), 1);
    chk("f256_frame_count", int'(frame_count), 0);

    // Move to h=5, v=3 and assert reset between edges.
    repeat (50) @(posedge clk_25); #1;
    chk("mid_hor", int'(vga_pos_hor), 5);
    chk("mid_ver", int'(vga_pos_ver), 3);
    #2;
    sys_reset = 1'b1;
    run = 1'b0;
    #1;
    chk("async_hor", int'(vga_pos_hor), HT - 1);
    chk("async_ver", int'(vga_pos_ver), VT - 1);
    chk("async_disp_en", int'(vga_disp_en), 0);
    chk("async_frame_count", int'(frame_count), 255);
    repeat (2) @(negedge clk_25);
    sys_reset = 1'b0;
    first_edge_checks("rerun");
    repeat (200) @(posedge clk_25);
    @(negedge clk_25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
